// File: rtl/echo_mix_stage.sv
// Echo mix stage: y[n] = sat(x[n] + (x[n-num] >>> SHIFT)) through a two-stage
// valid/ready pipeline, with per-job sample counting and a done pulse.
module echo_mix_stage #(
    parameter int SAMPLE_W = 16,
    parameter int SHIFT    = 1
) (
    input  logic                csi_clock_clk,
    input  logic                csi_clock_reset_n,
    input  logic                start,
    input  logic [18:0]         size,
    input  logic [10:0]         num,
    output logic                busy,
    output logic                done,
    output logic [18:0]         sat_count,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic [SAMPLE_W-1:0] in_delayed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
    localparam logic [1:0]  ST_DONE = 2'd2;
    localparam logic [18:0] SAT_MAX = 19'h7FFFF;

    // Clamp a one-bit-wide sum: the top two bits differ only on overflow.
    function automatic logic [SAMPLE_W-1:0] sat_word(input logic [SAMPLE_W:0] sum);
        logic [SAMPLE_W-1:0] w;
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
            w = {sum[SAMPLE_W], {(SAMPLE_W-1){~sum[SAMPLE_W]}}};
        end else begin
            w = sum[SAMPLE_W-1:0];
        end
        return w;
    endfunction

    logic [1:0]                r_state;
    logic [1:0]                w_state_nx;
    logic                      r_busy;
    logic                      r_done;
    logic [18:0]               r_size;
    logic [10:0]               r_num;
    logic [18:0]               r_in_idx;
    logic [18:0]               r_out_idx;
    logic [18:0]               r_sat_cnt;
    logic                      r_s1_valid;
    logic [SAMPLE_W:0]         r_s1_sum;
    logic                      r_s1_sat;
    logic                      r_s2_valid;
    logic [SAMPLE_W-1:0]       r_s2_data;

    logic                      w_s2_load;
    logic                      w_s1_load;
    logic                      w_in_ready;
    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_last_out;
    logic                      w_start_job;
    logic signed [SAMPLE_W-1:0] w_delay;
    logic signed [SAMPLE_W-1:0] w_echo;
    logic [SAMPLE_W:0]         w_sum;
    logic                      w_ovf;

    // Handshake and stall decode; S1 may fill while S2 is stalled if S1 is empty.
    always_comb begin
        w_s2_load   = !r_s2_valid || out_ready;
        w_s1_load   = !r_s1_valid || w_s2_load;
        w_in_ready  = (r_state == ST_RUN) && (r_in_idx < r_size) && w_s1_load;
        w_in_fire   = in_valid && w_in_ready;
        w_out_fire  = r_s2_valid && out_ready;
        w_last_out  = w_out_fire && ((r_out_idx + 19'd1) == r_size);
        w_start_job = (r_state == ST_IDLE) && start;
    end

    // Echo arithmetic; the delayed sample is muted until num samples have entered.
    always_comb begin
        if (r_in_idx < {8'd0, r_num}) begin
            w_delay = {SAMPLE_W{1'b0}};
        end else begin
            w_delay = in_delayed;
        end
        w_echo = w_delay >>> SHIFT;
        w_sum  = {in_sample[SAMPLE_W-1], in_sample} + {w_echo[SAMPLE_W-1], w_echo};
        w_ovf  = w_sum[SAMPLE_W] ^ w_sum[SAMPLE_W-1];
    end

    // Job state next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = (size != 19'd0) ? ST_RUN : ST_DONE;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last_out) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Job control registers and sample indices.
    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_size    <= 19'd0;
            r_num     <= 11'd0;
            r_in_idx  <= 19'd0;
            r_out_idx <= 19'd0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx == ST_RUN);
            r_done  <= (w_state_nx == ST_DONE);
            if (w_start_job) begin
                r_size    <= size;
                r_num     <= num;
                r_in_idx  <= 19'd0;
                r_out_idx <= 19'd0;
            end else begin
                if (w_in_fire) begin
                    r_in_idx <= r_in_idx + 19'd1;
                end
                if (w_out_fire) begin
                    r_out_idx <= r_out_idx + 19'd1;
                end
            end
        end
    end

    // Saturation counter: one count per clamped result entering S2, sticky at max.
    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) begin
            r_sat_cnt <= 19'd0;
        end else if (w_start_job) begin
            r_sat_cnt <= 19'd0;
        end else if (w_s2_load && r_s1_valid && r_s1_sat && (r_sat_cnt != SAT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + 19'd1;
        end
    end

    // Two-stage pipeline: S1 holds the wide sum, S2 holds the clamped result.
    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= {(SAMPLE_W+1){1'b0}};
            r_s1_sat   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= {SAMPLE_W{1'b0}};
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_s1_sum <= w_sum;
                    r_s1_sat <= w_ovf;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= sat_word(r_s1_sum);
                end
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign sat_count  = r_sat_cnt;
    assign in_ready   = w_in_ready;
    assign out_valid  = r_s2_valid;
    assign out_sample = r_s2_data;

endmodule

// File: tb/tb_echo_mix_stage.sv
// Directed bench for echo_mix_stage: job table of hand-computed vectors plus
// reset, size=0 and mid-job reset sequences.
module tb_echo_mix_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [18:0] size;
    logic [10:0] num;
    logic        busy;
    logic        done;
    logic [18:0] sat_count;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sample;
    logic [15:0] in_delayed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] dly;
        logic [15:0] y;
    } vec_t;

    typedef struct {
        int size;
        int num;
        int first;
        int exp_sat;
        bit bp;
        bit restart;
    } job_t;

    vec_t vecs [0:31];
    job_t jobs [0:4];

    echo_mix_stage #(.SAMPLE_W(16), .SHIFT(1)) dut (
        .csi_clock_clk     (clk),
        .csi_clock_reset_n (rst_n),
        .start             (start),
        .size              (size),
        .num               (num),
        .busy              (busy),
        .done              (done),
        .sat_count         (sat_count),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_sample         (in_sample),
        .in_delayed        (in_delayed),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_sample        (out_sample)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void setv(input int i, input int x, input int d, input int y);
        vecs[i].x   = x[15:0];
        vecs[i].dly = d[15:0];
        vecs[i].y   = y[15:0];
    endfunction

    // Start a job from the table, stream its pairs, check outputs and completion.
    task automatic run_job(input int j);
        int  in_ptr;
        int  out_ptr;
        int  first_acc;
        int  first_ov;
        int  last_out;
        bit  holding;
        bit  finished;
        logic [15:0] held;
        in_ptr = 0; out_ptr = 0; first_acc = -1; first_ov = -1; last_out = -10;
        holding = 1'b0; finished = 1'b0; held = 16'h0000;
        @(posedge clk); #1;
        start = 1'b1; size = jobs[j].size[18:0]; num = jobs[j].num[10:0];
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("busy_before_start_j%0d", j), {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            in_valid = 1'b1;
            if (in_ptr < jobs[j].size) begin
                in_sample  = vecs[jobs[j].first + in_ptr].x;
                in_delayed = vecs[jobs[j].first + in_ptr].dly;
            end else begin
                in_sample  = 16'h5A5A;
                in_delayed = 16'h5A5A;
            end
            out_ready = jobs[j].bp ? (cyc % 2 == 0) : 1'b1;
            start     = jobs[j].restart && (cyc == 2);
            size      = 19'd1;
            num       = 11'd0;
            @(negedge clk);
            if (cyc == 0) chk($sformatf("busy_after_start_j%0d", j), {31'd0, busy}, 32'd1);
            if (holding) begin
                chk($sformatf("hold_valid_j%0d", j), {31'd0, out_valid}, 32'd1);
                chk($sformatf("hold_sample_j%0d", j), {16'd0, out_sample}, {16'd0, held});
            end
            holding = 1'b0;
            if (done) begin
                finished = 1'b1;
                chk($sformatf("done_timing_j%0d", j), cyc, last_out + 1);
                chk($sformatf("busy_at_done_j%0d", j), {31'd0, busy}, 32'd0);
                chk($sformatf("out_count_j%0d", j), out_ptr, jobs[j].size);
                chk($sformatf("sat_count_j%0d", j), {13'd0, sat_count}, jobs[j].exp_sat);
                if (j == 0) chk("latency_j0", first_ov - first_acc, 32'd2);
            end else begin
                if (in_ptr == jobs[j].size) chk($sformatf("in_ready_drop_j%0d", j), {31'd0, in_ready}, 32'd0);
                if (in_valid && in_ready) begin
                    if (first_acc < 0) first_acc = cyc;
                    in_ptr++;
                end
                if (out_valid) begin
                    if (first_ov < 0) first_ov = cyc;
                    if (out_ready) begin
                        chk($sformatf("out_in_range_j%0d", j), {31'd0, (out_ptr < jobs[j].size)}, 32'd1);
                        if (out_ptr < jobs[j].size)
                            chk($sformatf("out_j%0d_%0d", j, out_ptr), {16'd0, out_sample},
                                {16'd0, vecs[jobs[j].first + out_ptr].y});
                        out_ptr++;
                        last_out = cyc;
                    end else begin
                        holding = 1'b1;
                        held    = out_sample;
                    end
                end
                @(posedge clk); #1;
            end
        end
        if (!finished) chk($sformatf("done_timeout_j%0d", j), {31'd0, done}, 32'd1);
        in_valid = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("done_one_cycle_j%0d", j), {31'd0, done}, 32'd0);
        chk($sformatf("busy_idle_j%0d", j), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; start = 1'b0; size = 19'd0; num = 11'd0;
        in_valid = 1'b1; out_ready = 1'b1; in_sample = 16'h1234; in_delayed = 16'h4321;

        // Basic echo: num=2, second start mid-run must be ignored.
        setv(0, 100, 7777, 100);
        setv(1, 200, -5, 200);
        setv(2, 300, 100, 350);
        setv(3, 400, 200, 500);
        // Saturation in both directions.
        setv(4, 30000, 8000, 32767);
        setv(5, -30000, -8000, -32768);
        // num beyond size: delayed input never contributes.
        setv(6, 1, -32768, 1);
        setv(7, -2, 32767, -2);
        setv(8, 32767, 32767, 32767);
        setv(9, -32768, -32768, -32768);
        setv(10, 1234, 999, 1234);
        // Backpressure job, num=0; last entry checks arithmetic shift of an odd negative.
        setv(11, 10, 2, 11);
        setv(12, -20, 4, -18);
        setv(13, 30, -6, 27);
        setv(14, -40, 8, -36);
        setv(15, 50, -10, 45);
        setv(16, -60, 12, -54);
        setv(17, 70, -14, 63);
        setv(18, -80, -3, -82);

        jobs[0] = '{4, 2, 0, 0, 1'b0, 1'b1};
        jobs[1] = '{2, 0, 4, 2, 1'b0, 1'b0};
        jobs[2] = '{5, 2047, 6, 0, 1'b0, 1'b0};
        jobs[3] = '{8, 0, 11, 0, 1'b1, 1'b0};
        jobs[4] = '{1, 0, 4, 1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sat_count", {13'd0, sat_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sample", {16'd0, out_sample}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_ready_no_start", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        for (int j = 0; j < 4; j++) run_job(j);

        // size=0: done one cycle after start, busy never rises.
        @(posedge clk); #1;
        start = 1'b1; size = 19'd0; num = 11'd5;
        @(negedge clk);
        chk("sz0_busy_pre", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("sz0_done", {31'd0, done}, 32'd1);
        chk("sz0_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("sz0_done_clear", {31'd0, done}, 32'd0);
        chk("sz0_busy_after", {31'd0, busy}, 32'd0);

        // Reset after 3 of 6 saturating accepts.
        @(posedge clk); #1;
        start = 1'b1; size = 19'd6; num = 11'd0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_sample = 16'd30000; in_delayed = 16'd8000; out_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("mid_accepts", acc, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_sat_count", {13'd0, sat_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", {31'd0, done}, 32'd0);
        end
        run_job(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
